// File: rtl/seg_scan_display.sv
// 6-digit common-anode 7-segment scanner: clamps and converts the binary display word to BCD
// with a sequential double-dabble engine, then drives one digit slot at a time.
module seg_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        en,
  input  logic        sign,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  localparam int          CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DIGITS - 1);
  localparam logic [19:0] VAL_MAX  = 20'd999999;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]    state;
  logic [4:0]    step;
  logic [19:0]   bin;
  logic [23:0]   bcd;
  logic [23:0]   bcd_adj;
  logic [5:0]    pt_s;
  logic          en_s;
  logic          sign_s;

  logic [23:0]   disp_bcd;
  logic [5:0]    disp_pt;
  logic          disp_en;
  logic          disp_sign;
  logic          loaded;

  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;

  logic [2:0]    msd;
  logic [3:0]    nib;
  logic [7:0]    code_nxt;
  logic [5:0]    sel_nxt;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= '0;
      bin       <= '0;
      bcd       <= '0;
      pt_s      <= '0;
      en_s      <= 1'b0;
      sign_s    <= 1'b0;
      disp_bcd  <= '0;
      disp_pt   <= '0;
      disp_en   <= 1'b0;
      disp_sign <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bin    <= (data > VAL_MAX) ? VAL_MAX : data;
          bcd    <= '0;
          pt_s   <= point;
          en_s   <= en;
          sign_s <= sign;
          step   <= '0;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd  <= {bcd_adj[22:0], bin[19]};
          bin  <= {bin[18:0], 1'b0};
          step <= step + 5'd1;
          if (step == 5'd19) state <= S_LOAD;
        end
        S_LOAD: begin
          disp_bcd  <= bcd;
          disp_pt   <= pt_s;
          disp_en   <= en_s;
          disp_sign <= sign_s;
          loaded    <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_TC) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A set point bit counts as significant so that e.g. 0.05 keeps its leading zeros
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 6; i++)
      if (disp_bcd[4*i +: 4] != 4'd0 || disp_pt[i]) msd = 3'(i);
  end

  always_comb begin
    nib      = disp_bcd[{idx, 2'b00} +: 4];
    code_nxt = 8'hFF;
    if (disp_en) begin
      if (idx <= msd) begin
        code_nxt = seg7(nib);
        if (disp_pt[idx]) code_nxt[7] = 1'b0;
      end else if (disp_sign && idx == msd + 3'd1) begin
        code_nxt = 8'hBF;
      end
    end
    sel_nxt = loaded ? ~(6'b1 << idx) : 6'h3F;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_sel <= 6'h3F;
      seg_led <= 8'hFF;
    end else begin
      seg_sel <= sel_nxt;
      seg_led <= loaded ? code_nxt : 8'hFF;
    end
  end

endmodule
